// File: rtl/apb_pkg.sv
// Shared types and constants for the native-to-APB requester bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // addr[31:16] selects the APB region, addr[15:12] the peripheral slot.
  localparam int REGION_LSB = 16;
  localparam int SLOT_LSB   = 12;
  localparam int SLOT_MSB   = 15;
  localparam int SLOT_W     = SLOT_MSB - SLOT_LSB + 1;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational region/slot decode of a core address into an APB slot index.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV = 4,
  parameter logic [15:0] BASE_HI = 16'h1000
) (
  input  logic [APB_ADDR_W-1:SLOT_LSB] i_addr_hi,
  output logic                         o_mapped,
  output logic [SLOT_W-1:0]            o_slot
);

  assign o_slot   = i_addr_hi[SLOT_MSB:SLOT_LSB];
  // One extra bit so that NUM_SLV = 16 still compares correctly.
  assign o_mapped = (i_addr_hi[APB_ADDR_W-1:REGION_LSB] == BASE_HI) &&
                    ({1'b0, o_slot} < 5'(NUM_SLV));

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns single core read/write requests into SETUP/ACCESS
// transfers on one of NUM_SLV slots, with decode errors and a hang timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV     = 4,
  parameter logic [15:0] BASE_HI     = 16'h1000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [APB_ADDR_W-1:0]   i_addr,
  input  logic [APB_DATA_W-1:0]   i_wdata,
  output logic [APB_DATA_W-1:0]   o_rdata,
  output logic                    o_ready,
  output logic                    o_err,
  output logic [APB_ADDR_W-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [NUM_SLV-1:0]      PSEL,
  output logic                    PENABLE,
  output logic [APB_DATA_W-1:0]   PWDATA,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  req_mapped;
  logic [SLOT_W-1:0]     req_slot;
  logic [NUM_SLV-1:0]    slot_oh;
  logic                  pready_sel;
  logic [APB_DATA_W-1:0] prdata_sel;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .BASE_HI (BASE_HI)
  ) u_dec (
    .i_addr_hi (i_addr[APB_ADDR_W-1:SLOT_LSB]),
    .o_mapped  (req_mapped),
    .o_slot    (req_slot)
  );

  // Only the latched slot's PREADY/PRDATA are looked at; others are ignored.
  always_comb begin
    slot_oh    = '0;
    prdata_sel = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      slot_oh[k] = (slot_q == SLOT_W'(k));
      if (slot_oh[k]) prdata_sel |= PRDATA[k*32 +: 32];
    end
    pready_sel = |(PREADY & slot_oh);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output is given a default first so no path
  // through the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_req) begin
          addr_d  = i_addr;
          we_d    = i_we;
          wdata_d = i_wdata;
          slot_d  = req_slot;
          rdata_d = '0;
          err_d   = !req_mapped;
          state_d = req_mapped ? SETUP : RESP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (pready_sel) begin
          rdata_d = we_q ? '0 : prdata_sel;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    o_ready = 1'b0;
    o_err   = 1'b0;
    o_rdata = '0;
    unique case (state_q)
      SETUP:  PSEL = slot_oh;
      ACCESS: begin
        PSEL    = slot_oh;
        PENABLE = 1'b1;
      end
      RESP: begin
        o_ready = 1'b1;
        o_err   = err_q;
        o_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign PADDR  = addr_q;
  assign PWRITE = we_q;
  assign PWDATA = wdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge with a behavioural
// APB slave array and a transaction-level reference model.
module tb_apb_master_bridge;

  localparam int NS = 4;
  localparam int TO = 8;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              i_req = 1'b0;
  logic              i_we = 1'b0;
  logic [31:0]       i_addr = '0;
  logic [31:0]       i_wdata = '0;
  logic [31:0]       o_rdata;
  logic              o_ready;
  logic              o_err;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [31:0]       PWDATA;
  logic [NS*32-1:0]  PRDATA = '0;
  logic [NS-1:0]     PREADY = '0;

  apb_master_bridge #(
    .NUM_SLV     (NS),
    .BASE_HI     (16'h1000),
    .TIMEOUT_CYC (TO)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_req   (i_req),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_ready (o_ready),
    .o_err   (o_err),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          t;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] sl_mem[logic [31:0]];
  int          slave_wait[NS];
  int          wcnt[NS];
  logic [31:0] cur_addr = '0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_wdata = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Slave array: slot k answers after slave_wait[k] ACCESS cycles; idle slots
  // drive random noise that the bridge has to ignore.
  always @(negedge PCLK) begin
    for (int k = 0; k < NS; k++) begin
      if (PSEL[k] && PENABLE) begin
        if (wcnt[k] >= slave_wait[k]) begin
          PREADY[k] = 1'b1;
          if (PWRITE) begin
            sl_mem[PADDR] = PWDATA;
            PRDATA[k*32 +: 32] = $urandom;
          end else begin
            PRDATA[k*32 +: 32] = sl_mem.exists(PADDR) ? sl_mem[PADDR] : dflt(PADDR);
          end
        end else begin
          PREADY[k] = 1'b0;
          PRDATA[k*32 +: 32] = $urandom;
          wcnt[k]++;
        end
      end else if (PSEL[k]) begin
        PREADY[k] = 1'b0;
        wcnt[k] = 0;
      end else begin
        PREADY[k] = 1'($urandom);
        PRDATA[k*32 +: 32] = $urandom;
        wcnt[k] = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and watches bus rules.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (o_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(o_ready), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_err", 32'(o_err), 32'(mon_e.err));
          check("resp_rdata", o_rdata, mon_e.rdata);
          check("resp_latency", 32'(cyc - mon_e.t), 32'(mon_e.lat));
        end
      end else begin
        check("idle_err", 32'(o_err), 32'd0);
        check("idle_rdata", o_rdata, 32'd0);
      end
      if (PSEL != '0) begin
        check("psel_onehot", 32'($onehot(PSEL)), 32'd1);
        check("paddr", PADDR, cur_addr);
        check("pwrite", 32'(PWRITE), 32'(cur_we));
        if (cur_we) check("pwdata", PWDATA, cur_wdata);
      end
      if (PENABLE) check("penable_with_psel", 32'(PSEL != '0), 32'd1);
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int wt);
    exp_t e;
    logic mapped;
    int   slot;
    bit   done;
    slot   = int'(addr[15:12]);
    mapped = (addr[31:16] == 16'h1000) && (slot < NS);
    e.err   = 1'b1;
    e.rdata = '0;
    e.lat   = 1;
    if (mapped && slot == 3) begin
      e.lat = 2 + TO;
    end else if (mapped) begin
      e.err = 1'b0;
      e.lat = 3 + wt;
      if (we) ref_mem[addr] = wdata;
      else    e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
    end
    @(negedge PCLK);
    if (mapped) slave_wait[slot] = (slot == 3) ? 1000 : wt;
    i_req     = 1'b1;
    i_we      = we;
    i_addr    = addr;
    i_wdata   = wdata;
    cur_addr  = addr;
    cur_we    = we;
    cur_wdata = wdata;
    e.t = cyc;
    sb.push_back(e);
    if (mapped) begin
      @(negedge PCLK);
      check("setup_psel", 32'(PSEL), 32'(1 << slot));
      check("setup_penable", 32'(PENABLE), 32'd0);
      @(negedge PCLK);
      check("access_psel", 32'(PSEL), 32'(1 << slot));
      check("access_penable", 32'(PENABLE), 32'd1);
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (o_ready) done = 1'b1;
      else @(negedge PCLK);
    end
    if (!done) begin
      check("resp_timeout", 32'(done), 32'd1);
      sb.delete();
    end
    i_req = 1'b0;
  endtask

  task automatic reset_mid_access();
    @(negedge PCLK);
    slave_wait[3] = 1000;
    i_req    = 1'b1;
    i_we     = 1'b0;
    i_addr   = 32'h1000_3004;
    cur_addr = 32'h1000_3004;
    cur_we   = 1'b0;
    repeat (3) @(negedge PCLK);
    check("pre_reset_penable", 32'(PENABLE), 32'd1);
    #2 PRESET = 1'b1;
    #1;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    i_req = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          s;
    for (int k = 0; k < NS; k++) begin
      slave_wait[k] = 0;
      wcnt[k] = 0;
    end
    ref_mem[32'h1000_2008] = 32'h3132_3334;
    sl_mem[32'h1000_2008]  = 32'h3132_3334;

    repeat (2) @(negedge PCLK);
    check("rst_state_psel", 32'(PSEL), 32'd0);
    check("rst_state_penable", 32'(PENABLE), 32'd0);
    check("rst_state_ready", 32'(o_ready), 32'd0);
    check("rst_state_err", 32'(o_err), 32'd0);
    check("rst_state_rdata", o_rdata, 32'd0);
    check("rst_state_paddr", PADDR, 32'd0);
    check("rst_state_pwrite", 32'(PWRITE), 32'd0);
    check("rst_state_pwdata", PWDATA, 32'd0);
    PRESET = 1'b0;

    do_req(1'b1, 32'h1000_0000, 32'h0000_0001, 0);
    do_req(1'b0, 32'h1000_2008, 32'h0, 1);
    do_req(1'b0, 32'h2000_0000, 32'h0, 0);
    do_req(1'b0, 32'h1000_5000, 32'h0, 0);
    do_req(1'b0, 32'h1000_3000, 32'h0, 0);
    do_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 0);
    do_req(1'b1, 32'h1000_1010, 32'hCAFE_F00D, 0);
    do_req(1'b0, 32'h1000_0010, 32'h0, 2);
    do_req(1'b0, 32'h1000_1010, 32'h0, 0);

    reset_mid_access();
    do_req(1'b0, 32'h1000_2008, 32'h0, 1);

    for (int n = 0; n < 80; n++) begin
      s = int'($urandom_range(0, 9));
      if (s <= 5)      a = {16'h1000, 4'($urandom_range(0, 2)), 8'h00, 2'($urandom_range(0, 3)), 2'b00};
      else if (s == 6) a = {16'h1000, 4'd3, 12'($urandom)};
      else if (s == 7) a = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
      else if (s == 8) a = {16'h2000 + 16'($urandom_range(0, 10)), 16'($urandom)};
      else             a = {16'h1000, 4'($urandom_range(0, 2)), 12'($urandom)};
      do_req(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge PCLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Native-to-APB bridge: the APB requester (initiator) side of the peripheral bus.
- Accepts single 32-bit read/write requests from the RISC-V core's data-memory port.
- Generates APB3 SETUP/ACCESS phases and decodes the address into one PSEL per peripheral slot.
- Returns read data, ready and error to the core; aborts hung transfers via timeout.

Parameters:
- NUM_SLV, 4: number of peripheral slots (PSEL width); range 1..16.
- BASE_HI, 16'h1000: required value of addr[31:16] for the APB region.
- TIMEOUT_CYC, 255: max ACCESS cycles without PREADY before abort; range 1..255.

Ports:
- PCLK  in  1  bus clock
- PRESET  in  1  reset
- i_req  in  1  request strobe; sampled only in IDLE
- i_we  in  1  1 = write, 0 = read
- i_addr  in  32  byte address
- i_wdata  in  32  write data
- o_rdata  out  32  read data; valid while o_ready = 1
- o_ready  out  1  one-cycle completion pulse
- o_err  out  1  qualifies o_ready: unmapped address or timeout
- PADDR  out  32  APB address
- PWRITE  out  1  APB direction
- PSEL  out  NUM_SLV  one-hot slave select
- PENABLE  out  1  APB access phase
- PWDATA  out  32  APB write data
- PRDATA  in  NUM_SLV*32  slave read data; slot k at bits [32k+31:32k]
- PREADY  in  NUM_SLV  per-slave ready

Behaviour:
- Reset is PRESET, asynchronous, active-high; clock is PCLK.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Decode:
  - Mapped when addr[31:16] == BASE_HI and addr[15:12] < NUM_SLV; slot k = addr[15:12].
  - Everything else is unmapped.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On i_req = 1, latch i_addr/i_we/i_wdata/slot into registers.
  - Mapped: go to SETUP. Unmapped: go to RESP with err = 1 and rdata = 0.
  - i_req is ignored in all other states; the core holds it until o_ready.
- SETUP (exactly 1 cycle): PSEL[k] = 1, PENABLE = 0, PADDR/PWRITE/PWDATA driven from latched values; then ACCESS.
- ACCESS:
  - PSEL[k] = 1, PENABLE = 1; timeout counter increments each cycle.
  - PREADY[k] = 1: capture PRDATA slot k when read (0 when write); go to RESP with err = 0.
  - Counter reaches TIMEOUT_CYC with PREADY[k] low: go to RESP with err = 1 and rdata = 0.
  - PREADY/PRDATA of unselected slots are ignored.
- RESP (1 cycle):
  - PSEL = 0, PENABLE = 0; o_ready = 1, o_err = latched err, o_rdata = latched data; then IDLE.
  - o_rdata returns to 0 in IDLE.
- PADDR/PWRITE/PWDATA hold their values through SETUP and ACCESS, may hold afterwards, and are 0 after reset.
- Latency, with the request sampled at cycle T:
  - SETUP at T+1; ACCESS from T+2.
  - Zero-wait slave (PREADY = 1 at T+2): o_ready at T+3.
  - Registered-PREADY slave (ready at T+3): o_ready at T+4.
  - Unmapped address: o_ready/o_err at T+1.
  - Timeout: o_ready at T+2+TIMEOUT_CYC.
- Back-to-back: a new request can be sampled earliest in the cycle after RESP; minimum spacing is 4 cycles.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async), no o_ready pulse, FSM returns to IDLE.
- PSEL is never multi-hot. PENABLE = 1 only with a PSEL bit set.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - APB_ADDR_W = 32, APB_DATA_W = 32
  - region and slot-field constants (SLOT_LSB = 12, SLOT_MSB = 15)
- Sub-module apb_addr_decoder (combinational): i_addr -> {mapped, slot index}.
- FSM, timeout counter and read mux stay in the top module.

Test Plan:
- Write 0x0000_0001 to 0x1000_0000 with slot 0 PREADY tied high -> PSEL = 4'b0001 at T+1, PENABLE at T+2, PWDATA = 1 through both phases, o_ready = 1/o_err = 0 at T+3.
- Read 0x1000_2008 with slot 2 returning PRDATA = 0x3132_3334 and one wait state -> PSEL = 4'b0100, PADDR = 0x1000_2008, o_rdata = 0x3132_3334 at T+4; a differing PRDATA on slot 1 has no effect.
- Read unmapped 0x2000_0000 and 0x1000_5000 (NUM_SLV = 4) -> PSEL stays 0, o_ready = o_err = 1 at T+1, o_rdata = 0.
- Slot 3 PREADY held low with TIMEOUT_CYC = 8 -> PENABLE high for 8 cycles, then PSEL drops, o_ready = o_err = 1 at T+10.
- Two writes issued back-to-back to slots 0 and 1 -> second SETUP no earlier than 4 cycles after the first; no overlap of PSEL bits.
- PRESET asserted during ACCESS -> PSEL/PENABLE = 0 in the same cycle, no o_ready; a subsequent read completes normally.
